// File: rtl/mem_arbiter_pkg.sv
// Shared types and default sizing for the unified-memory arbiter slice.
// `ARB_PC_SIZE` / `ARB_DATA_SIZE` may be overridden on the command line before this file.
`ifndef ARB_PC_SIZE
`define ARB_PC_SIZE 16
`endif
`ifndef ARB_DATA_SIZE
`define ARB_DATA_SIZE 32
`endif

package mem_arb_pkg;

  localparam int unsigned PC_SIZE         = `ARB_PC_SIZE;
  localparam int unsigned DATA_SIZE       = `ARB_DATA_SIZE;
  localparam int unsigned DEF_MEM_LATENCY = 2;
  localparam int unsigned DEF_IWORDS      = 4;
  localparam int unsigned DEF_DBASE       = 'h400;

  typedef enum logic [2:0] {
    IDLE,
    IBURST,
    DREAD,
    DWRITE,
    DONE
  } arb_state_e;

  typedef enum logic {
    GNT_I,
    GNT_D
  } grant_side_e;

endpackage

// File: rtl/mem_arbiter_if.sv
// Bundle of the instruction-refill, data-access and unified-memory signals.
// slave: the arbiter's view; master: the core/memory side driving it.
interface mem_arbiter_if
  import mem_arb_pkg::*;
#(
  parameter int unsigned IWORDS = DEF_IWORDS
);

  logic                        i_req;
  logic [PC_SIZE-1:0]          i_addr;
  logic [IWORDS*DATA_SIZE-1:0] i_word;
  logic                        i_word_ready;
  logic                        d_re;
  logic                        d_we;
  logic [8:0]                  d_addr;
  logic [DATA_SIZE-1:0]        d_wdata;
  logic [DATA_SIZE-1:0]        d_rdata;
  logic                        d_ready;
  logic                        mem_en;
  logic                        mem_we;
  logic [PC_SIZE-1:0]          mem_addr;
  logic [DATA_SIZE-1:0]        mem_wdata;
  logic [DATA_SIZE-1:0]        mem_rdata;

  modport slave (
    input  i_req, i_addr, d_re, d_we, d_addr, d_wdata, mem_rdata,
    output i_word, i_word_ready, d_rdata, d_ready,
           mem_en, mem_we, mem_addr, mem_wdata
  );

  modport master (
    output i_req, i_addr, d_re, d_we, d_addr, d_wdata, mem_rdata,
    input  i_word, i_word_ready, d_rdata, d_ready,
           mem_en, mem_we, mem_addr, mem_wdata
  );

endinterface

// File: rtl/mem_arbiter_rd_tracker.sv
// Read-return tracker: a MEM_LATENCY-deep valid/beat-index pipe whose tail
// marks the cycle in which mem_rdata belongs to a given issued beat.
module arb_rd_tracker #(
  parameter int unsigned MEM_LATENCY = 2,
  parameter int unsigned IDXW        = 2
) (
  input  logic            clk,
  input  logic            nrst,
  input  logic            issue,
  input  logic [IDXW-1:0] issue_idx,
  output logic            cap,
  output logic [IDXW-1:0] cap_idx
);

  logic [MEM_LATENCY-1:0]           vld_q, vld_d;
  logic [MEM_LATENCY-1:0][IDXW-1:0] idx_q, idx_d;

  always_comb begin
    vld_d    = vld_q;
    idx_d    = idx_q;
    vld_d[0] = issue;
    idx_d[0] = issue_idx;
    for (int unsigned i = 1; i < MEM_LATENCY; i++) begin
      vld_d[i] = vld_q[i-1];
      idx_d[i] = idx_q[i-1];
    end
  end

  always_ff @(posedge clk) begin
    if (!nrst) begin
      vld_q <= '0;
      idx_q <= '0;
    end else begin
      vld_q <= vld_d;
      idx_q <= idx_d;
    end
  end

  assign cap     = vld_q[MEM_LATENCY-1];
  assign cap_idx = idx_q[MEM_LATENCY-1];

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates instruction-line refills and data accesses onto one memory port.
// Define ARB_ROUND_ROBIN_EN for round-robin on conflicts; otherwise data wins.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned MEM_LATENCY = DEF_MEM_LATENCY,
  parameter int unsigned IWORDS      = DEF_IWORDS,
  parameter int unsigned DBASE       = DEF_DBASE
) (
  input logic          clk,
  input logic          nrst,
  mem_arbiter_if.slave bus
);

  localparam int unsigned        IDXW      = (IWORDS > 1) ? $clog2(IWORDS) : 1;
  localparam int unsigned        CNTW      = $clog2(IWORDS + 1);
  localparam int unsigned        WORD_W    = IWORDS * DATA_SIZE;
  localparam logic [PC_SIZE-1:0] LINE_MASK = ~PC_SIZE'(IWORDS - 1);
  localparam logic [PC_SIZE-1:0] DBASE_A   = PC_SIZE'(DBASE);

  arb_state_e           state_q, state_d;
  grant_side_e          side_q, side_d;
  logic [CNTW-1:0]      beat_q, beat_d;
  logic [CNTW-1:0]      cap_cnt_q, cap_cnt_d;
  logic [PC_SIZE-1:0]   base_q, base_d;
  logic [8:0]           daddr_q, daddr_d;
  logic [DATA_SIZE-1:0] dwdata_q, dwdata_d;
  logic [WORD_W-1:0]    iword_q, iword_d;
  logic [DATA_SIZE-1:0] rdata_q, rdata_d;

  logic                 mem_en, mem_we;
  logic [PC_SIZE-1:0]   mem_addr;
  logic [DATA_SIZE-1:0] mem_wdata;
  logic                 cap;
  logic [IDXW-1:0]      cap_idx;
  logic                 d_any, pick_d;

  assign d_any = bus.d_re | bus.d_we;

`ifdef ARB_ROUND_ROBIN_EN
  grant_side_e rr_last_q, rr_last_d;

  // On a conflict, data wins only if instruction was served last.
  assign pick_d = d_any && (!bus.i_req || rr_last_q == GNT_I);

  always_comb begin
    rr_last_d = rr_last_q;
    if (state_q == IDLE && (bus.i_req || d_any))
      rr_last_d = pick_d ? GNT_D : GNT_I;
  end

  always_ff @(posedge clk) begin
    if (!nrst) rr_last_q <= GNT_I;
    else       rr_last_q <= rr_last_d;
  end
`else
  assign pick_d = d_any;
`endif

  arb_rd_tracker #(
    .MEM_LATENCY (MEM_LATENCY),
    .IDXW        (IDXW)
  ) u_trk (
    .clk       (clk),
    .nrst      (nrst),
    .issue     (mem_en & ~mem_we),
    .issue_idx (beat_q[IDXW-1:0]),
    .cap       (cap),
    .cap_idx   (cap_idx)
  );

  always_comb begin
    state_d   = state_q;
    side_d    = side_q;
    beat_d    = beat_q;
    cap_cnt_d = cap_cnt_q;
    base_d    = base_q;
    daddr_d   = daddr_q;
    dwdata_d  = dwdata_q;
    iword_d   = iword_q;
    rdata_d   = rdata_q;
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;

    if (cap) begin
      if (side_q == GNT_I) iword_d[cap_idx*DATA_SIZE +: DATA_SIZE] = bus.mem_rdata;
      else                 rdata_d = bus.mem_rdata;
    end

    unique case (state_q)
      IDLE: begin
        beat_d    = '0;
        cap_cnt_d = '0;
        if (pick_d) begin
          side_d   = GNT_D;
          daddr_d  = bus.d_addr;
          dwdata_d = bus.d_wdata;
          state_d  = bus.d_we ? DWRITE : DREAD;
        end else if (bus.i_req) begin
          side_d  = GNT_I;
          base_d  = bus.i_addr & LINE_MASK;
          state_d = IBURST;
        end
      end
      // Issue runs ahead of capture; leave only once the last beat has landed.
      IBURST: begin
        if (beat_q < CNTW'(IWORDS)) begin
          mem_en   = 1'b1;
          mem_addr = base_q + PC_SIZE'(beat_q);
          beat_d   = beat_q + CNTW'(1);
        end
        if (cap) begin
          cap_cnt_d = cap_cnt_q + CNTW'(1);
          if (cap_cnt_q == CNTW'(IWORDS - 1)) state_d = DONE;
        end
      end
      DREAD: begin
        if (beat_q == '0) begin
          mem_en   = 1'b1;
          mem_addr = DBASE_A + PC_SIZE'(daddr_q);
          beat_d   = CNTW'(1);
        end
        if (cap) state_d = DONE;
      end
      DWRITE: begin
        mem_en    = 1'b1;
        mem_we    = 1'b1;
        mem_addr  = DBASE_A + PC_SIZE'(daddr_q);
        mem_wdata = dwdata_q;
        state_d   = DONE;
      end
      DONE: begin
        beat_d    = '0;
        cap_cnt_d = '0;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!nrst) begin
      state_q   <= IDLE;
      side_q    <= GNT_I;
      beat_q    <= '0;
      cap_cnt_q <= '0;
      base_q    <= '0;
      daddr_q   <= '0;
      dwdata_q  <= '0;
      iword_q   <= '0;
      rdata_q   <= '0;
    end else begin
      state_q   <= state_d;
      side_q    <= side_d;
      beat_q    <= beat_d;
      cap_cnt_q <= cap_cnt_d;
      base_q    <= base_d;
      daddr_q   <= daddr_d;
      dwdata_q  <= dwdata_d;
      iword_q   <= iword_d;
      rdata_q   <= rdata_d;
    end
  end

  assign bus.i_word       = iword_q;
  assign bus.d_rdata      = rdata_q;
  assign bus.i_word_ready = (state_q == DONE) && (side_q == GNT_I);
  assign bus.d_ready      = (state_q == DONE) && (side_q == GNT_D);
  assign bus.mem_en       = mem_en;
  assign bus.mem_we       = mem_we;
  assign bus.mem_addr     = mem_addr;
  assign bus.mem_wdata    = mem_wdata;

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 The block SHALL have parameter MEM_LATENCY, default 2, meaning cycles from a mem_en read issue to valid mem_rdata (range 1..7).
REQ-002 The block SHALL have parameter IWORDS, default 4, meaning `data_size`-wide beats per instruction line; `memory_word` SHALL equal IWORDS*`data_size`.
REQ-003 The block SHALL have parameter DBASE, default 'h400, meaning the word offset added to every data address.
REQ-004 The block SHALL have the ports listed below, clock and reset first.
- clk  in  1  clock; reset nrst, synchronous, active-low; clock clk.
- nrst  in  1  synchronous active-low reset.
- i_req  in  1  instruction-line refill request (core i_miss).
- i_addr  in  `pc_size`  refill address; low log2(IWORDS) bits ignored.
- i_word  out  `memory_word`  assembled line; beat 0 in the LSBs.
- i_word_ready  out  1  one-cycle pulse, line valid.
- d_re  in  1  data read request.
- d_we  in  1  data write request.
- d_addr  in  9  data word address.
- d_wdata  in  `data_size`  write data.
- d_rdata  out  `data_size`  read data.
- d_ready  out  1  one-cycle pulse, data access complete.
- mem_en  out  1  unified memory access strobe.
- mem_we  out  1  unified memory write strobe.
- mem_addr  out  `pc_size`  unified memory word address.
- mem_wdata  out  `data_size`  unified memory write data.
- mem_rdata  in  `data_size`  unified memory read data.

Function
REQ-005 The FSM SHALL have the states IDLE, IBURST, DREAD, DWRITE and DONE.
REQ-006 A grant SHALL be decided only in IDLE; the arbitrating cycle is T.
REQ-007 On an I-grant, IBURST SHALL issue beats k=0..IWORDS-1 in cycles T+1+k with mem_addr = line base + k.
REQ-008 Each I beat SHALL be captured from mem_rdata at T+1+k+MEM_LATENCY.
REQ-009 i_word_ready SHALL pulse in cycle T+IWORDS+MEM_LATENCY+1, in DONE.
REQ-010 On a D-read grant, the access SHALL issue at T+1 with mem_addr = DBASE + d_addr, zero-extended.
REQ-011 The D-read data SHALL be captured at T+1+MEM_LATENCY, and d_ready SHALL pulse at T+2+MEM_LATENCY.
REQ-012 On a D-write grant, mem_en and mem_we SHALL assert at T+1, and d_ready SHALL pulse at T+2.
REQ-013 If d_re and d_we are both high, the access SHALL be treated as a write.
REQ-014 DONE SHALL last one cycle, ignore all requests, and return to IDLE.
REQ-015 Requesters SHALL hold their request until their ready pulse and drop it on the next edge.
REQ-016 A request deasserted during a burst or access SHALL NOT abort it; the transaction SHALL complete and its ready SHALL still pulse.
REQ-017 mem_en SHALL be high only in issue cycles, and mem_we only in DWRITE.
REQ-018 mem_addr and mem_wdata SHALL be 0 whenever mem_en is low.
REQ-019 i_word and d_rdata SHALL hold their last captured value until overwritten.
REQ-020 Beat and in-flight counters SHALL not wrap within a transaction and SHALL clear on return to IDLE.

Reset
REQ-021 While nrst=0 at a clock edge, the FSM SHALL go to IDLE.
REQ-022 While nrst=0 at a clock edge, all counters SHALL be 0, all outputs SHALL be 0, and the round-robin pointer SHALL point to I.
REQ-023 A reset mid-burst SHALL discard in-flight beats, and no ready pulse SHALL follow.

Configuration
REQ-024 With ARB_ROUND_ROBIN_EN defined, simultaneous i_req and d_re/d_we SHALL be granted to the side not served last, and the pointer SHALL update on every grant.
REQ-025 Without ARB_ROUND_ROBIN_EN, the data side SHALL always win simultaneous requests.

Structure
REQ-026 Package mem_arb_pkg SHALL hold the arb_state enum, the grant_side enum (GNT_I, GNT_D) and the default parameter constants.
REQ-027 Sub-module arb_rd_tracker SHALL be a MEM_LATENCY-deep valid/beat-index shift pipe that produces capture strobes.

Verification
REQ-028 i_req=1, i_addr='h13, mem returns 'hA0+addr -> beats issued to 'h10..'h13 at T+1..T+4; i_word_ready at T+7; i_word={'hB3,'hB2,'hB1,'hB0}.
REQ-029 d_re=1, d_addr='h005 -> mem_addr='h405 at T+1; d_ready at T+4; d_rdata = mem_rdata sampled at T+3.
REQ-030 d_we=1, d_addr='h1FF, d_wdata='hDEADBEEF -> mem_we=1, mem_addr='h5FF at T+1; d_ready at T+2.
REQ-031 i_req and d_re raised in the same cycle, twice back-to-back -> default build: D, I, D, I; ARB_ROUND_ROBIN_EN build: D, I, then alternating from the pointer.
REQ-032 nrst=0 at T+3 of an I-burst -> IDLE next cycle; no i_word_ready; mem_en=0.
REQ-033 d_re=d_we=1 -> a write occurs and d_ready pulses at T+2.
